pc: RTL and testbench

16-bit program counter register for the CPU datapath. Holds the address of the current instruction and updates once per rising clock edge: it clears on reset, loads a jump target from the datapath, or steps to the next sequential address. The output drives the instruction memory address bus directly.

---
 rtl/pc.sv | 27 ++
 tb/tb_pc.sv | 117 +++++++++++
 2 files changed

// File: rtl/pc.sv
`timescale 1ns/1ps
// Program counter: registered WIDTH-bit address with reset > load > inc > hold priority.
// Latency is one cycle for every operation; there is no backpressure, and a control is accepted on every edge.
module pc #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] out
);

  // The increment wraps naturally modulo 2^WIDTH, and no carry is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= RESET_VALUE;
    end else if (load) begin
      out <= in;
    end else if (inc) begin
      out <= out + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pc.sv
`timescale 1ns/1ps
// Directed test for pc: reset, load, increment, wrap, priority and sampling-edge behaviour.
module tb_pc;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        inc;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  pc #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .load (load),
    .inc  (inc),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply the controls, let one rising edge pass, then settle 1 ns before the caller samples.
  task automatic cyc(input logic r, input logic l, input logic i, input logic [15:0] d);
    reset = r;
    load  = l;
    inc   = i;
    in    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    inc   = 1'b0;
    in    = 16'h0000;

    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    check("reset", out, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("hold_after_reset", out, 16'h0000);

    cyc(1'b0, 1'b1, 1'b0, 16'hA5A5);
    check("load_a5a5", out, 16'hA5A5);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("hold_a5a5", out, 16'hA5A5);

    cyc(1'b0, 1'b0, 1'b1, 16'h0000);
    check("inc_a5a6", out, 16'hA5A6);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("hold_a5a6", out, 16'hA5A6);

    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    check("reset_after_activity", out, 16'h0000);

    cyc(1'b0, 1'b1, 1'b0, 16'hFFFF);
    check("load_ffff", out, 16'hFFFF);
    cyc(1'b0, 1'b0, 1'b1, 16'h0000);
    check("wrap", out, 16'h0000);

    cyc(1'b0, 1'b1, 1'b1, 16'h1234);
    check("load_beats_inc", out, 16'h1234);

    // A reset raised between edges must not affect out until the next edge.
    reset = 1'b1;
    load  = 1'b1;
    inc   = 1'b1;
    #2;
    check("reset_is_sync", out, 16'h1234);
    cyc(1'b1, 1'b1, 1'b1, 16'h1234);
    check("reset_beats_all", out, 16'h0000);

    cyc(1'b0, 1'b0, 1'b1, 16'h0000);
    check("inc_run_1", out, 16'h0001);
    cyc(1'b0, 1'b0, 1'b1, 16'h0000);
    check("inc_run_2", out, 16'h0002);
    cyc(1'b0, 1'b0, 1'b1, 16'h0000);
    check("inc_run_3", out, 16'h0003);

    // Inputs pulsed and removed between edges have no effect.
    inc  = 1'b0;
    in   = 16'hBEEF;
    load = 1'b1;
    #2;
    load = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 16'hBEEF);
    check("glitch_ignored", out, 16'h0003);

    cyc(1'b0, 1'b1, 1'b0, 16'h00FF);
    check("load_00ff", out, 16'h00FF);
    cyc(1'b0, 1'b0, 1'b1, 16'h0000);
    check("inc_carry", out, 16'h0100);

    // Reset in the middle of an increment run discards the pending increment.
    cyc(1'b1, 1'b0, 1'b1, 16'h0000);
    check("reset_mid_inc", out, 16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 16'h0000);
    check("resume_after_reset", out, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
